pic_cmd_regfile: RTL
====================

// Module: pic_cmd_regfile
// PURPOSE
//  Parametrised, clocked successor to the PIC read/write control and data-bus buffer.
//  - Synchronises the CPU rdn/wrn strobes and runs the ICW1..ICW4 initialisation sequence.
//  - Decodes OCW1/OCW2/OCW3 writes and drives the read-back mux (IRR/ISR/IMR/poll).
//  - Exports the configuration fields to the priority resolver and cascade logic.
// PARAMETERS
//  DW          8   data bus width; must be >= 8; command fields occupy bits [7:0], upper bits read 0
//  NIRQ        8   interrupt lines; 1..DW; width of irr/isr/imr
//  SYNC_STAGES 2   flops in each strobe synchroniser; must be >= 2
// PORTS
//  clk        in   1     system clock; all state on rising edge
//  rstn       in   1     asynchronous active-low reset
//  csn        in   1     chip select, active low
//  rdn        in   1     CPU read strobe, active low, asynchronous to clk
//  wrn        in   1     CPU write strobe, active low, asynchronous to clk
//  a0         in   1     register-select address bit
//  d_in       in   DW    CPU write data
//  d_out      out  DW    read data; valid while d_oe=1
//  d_oe       out  1     tri-state enable for the external data pad
//  irr        in   NIRQ  interrupt request register from the edge/level block
//  isr        in   NIRQ  in-service register from the priority resolver
//  imr        out  NIRQ  interrupt mask (OCW1)
//  icw1..icw4 out  8     captured ICW bytes; icw3/icw4 read 0 when skipped
//  ocw2       out  8     last OCW2 byte
//  ocw2_stb   out  1     one-cycle pulse when an OCW2 is committed
//  smm        out  1     special mask mode, from OCW3 ESMM/SMM
//  init_done  out  1     high in state READY
// BEHAVIOUR
//  - Reset: all outputs 0, state WAIT_ICW1, ris=0 (IRR read select), d_oe=0.
//  - Strobes: each of rdn/wrn/csn passes through SYNC_STAGES flops.
//  - Sampling: while synced wrn=0 and csn=0, a0 and d_in are registered every cycle.
//  - Write commit: on the synced wrn rising edge, using the last sample.
//  - Write latency: SYNC_STAGES+1 clk from the wrn pin rise; output registers update that cycle.
//  - Write decode, evaluated before the state decode:
//    a0=0 & d[4]=1: ICW1. Restart from any state: icw1<=d, icw2..4<=0, imr<=0, ris<=0, smm<=0;
//      state->WAIT_ICW2.
//    a0=1 in WAIT_ICW2: icw2<=d. Next state:
//      WAIT_ICW3 if icw1[1]=0 (cascade);
//      else WAIT_ICW4 if icw1[0]=1;
//      else READY.
//    a0=1 in WAIT_ICW3: icw3<=d. Next state: WAIT_ICW4 if icw1[0]=1, else READY.
//    a0=1 in WAIT_ICW4: icw4<=d; state->READY.
//    a0=1 in READY: OCW1, imr<=d[NIRQ-1:0].
//    a0=0 & d[4:3]=00 in READY: ocw2<=d; ocw2_stb=1 for exactly one clk.
//    a0=0 & d[4:3]=01 in READY: OCW3.
//      d[1]=1 (RR): ris<=d[0].
//      d[6]=1 (ESMM): smm<=d[5].
//    Any other write, including OCW writes before READY: ignored, state unchanged.
//  - Read: d_oe = synced (~csn & ~rdn). d_out is registered every cycle while d_oe=1:
//    a0=1: imr; a0=0 & ris=0: irr; a0=0 & ris=1: isr; zero-extended to DW.
//    d_out holds its last value when d_oe=0.
//  - Simultaneous events:
//    rdn and wrn both low at the wrn rising edge: write discarded, read proceeds.
//    csn rising before wrn: write discarded.
//  - Reset mid-operation: returns immediately to reset values; a partial ICW sequence is lost.
//  - State machine: WAIT_ICW1 -> WAIT_ICW2 -> [WAIT_ICW3] -> [WAIT_ICW4] -> READY.
//    ICW1 from any state -> WAIT_ICW2.
// CONFIGURATION
//  PIC_POLL_EN defined:
//  - OCW3 with d[2]=1 (P) sets poll_pend.
//  - The next read with a0=0 returns {isr_any_req, 4'b0, lvl[2:0]}, where lvl is the lowest
//    set irr index; bit 7 is 1 if irr!=0.
//  - poll_ack output pulses one clk at d_oe fall, then poll_pend clears.
//  PIC_POLL_EN undefined: P bit ignored; no poll_ack port; reads as above.
// STRUCTURE
//  - pic_pkg: state enum (WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY);
//    ICW1 bit indices IC4=0, SNGL=1; OCW3 bit indices RIS=0, RR=1, P=2, SMM=5, ESMM=6;
//    decode masks.
//  - Sub-module pic_strobe_sync: SYNC_STAGES-flop synchroniser plus rise/fall detect;
//    reset value 1 (inactive). Instantiated for rdn, wrn, csn.
// TESTING
//  - Single mode: ICW1=0x13, ICW2=0x20, ICW4=0x01 -> WAIT_ICW3 skipped, icw3=0, init_done=1,
//    icw2=0x20.
//  - Cascade mode: ICW1=0x11, 0x08, 0x04, 0x01 -> all four captured; init_done after the 4th write.
//  - OCW1=0xA5, read a0=1 -> d_out=0xA5.
//    OCW3=0x0B, irr=0x0F, isr=0x02: read a0=0 -> 0x02.
//    OCW3=0x0A: read a0=0 -> 0x0F.
//  - OCW2=0x20 -> ocw2_stb high exactly 1 clk, ocw2=0x20.
//    OCW2 sent before READY -> no pulse.
//  - ICW1 rewrite while in READY with imr=0xFF -> imr=0, init_done=0, state WAIT_ICW2.
//    rstn low mid-sequence -> all outputs 0.
//  - rdn and wrn low together -> write dropped.
//    PIC_POLL_EN, irr=0x10, OCW3=0x0C, read -> 0x84; poll_ack pulses once.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: state/command types, ICW/OCW bit indices and write decode
// shared by the PIC command register file.
`timescale 1ns/1ps
package pic_pkg;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } pic_state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ICW1,
        CMD_ICWN,
        CMD_OCW1,
        CMD_OCW2,
        CMD_OCW3
    } pic_cmd_e;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;

    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    localparam logic [7:0] ICW1_MASK = 8'h10;
    localparam logic [7:0] OCW_MASK  = 8'h18;
    localparam logic [7:0] OCW2_SEL  = 8'h00;
    localparam logic [7:0] OCW3_SEL  = 8'h08;

    // ICW1 wins over everything; OCWs only decode once initialised
    function automatic pic_cmd_e cmd_decode(
        input logic       a0,
        input logic [7:0] d,
        input logic       ready
    );
        pic_cmd_e cmd;
        cmd = CMD_NONE;
        unique case (1'b1)
            (!a0 && ((d & ICW1_MASK) != 8'h00)):
                cmd = CMD_ICW1;
            (a0 && !ready):
                cmd = CMD_ICWN;
            (a0 && ready):
                cmd = CMD_OCW1;
            (!a0 && ready && ((d & OCW_MASK) == OCW2_SEL)):
                cmd = CMD_OCW2;
            (!a0 && ready && ((d & OCW_MASK) == OCW3_SEL)):
                cmd = CMD_OCW3;
            default:
                cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/pic_strobe_sync.sv
// pic_strobe_sync: multi-flop synchroniser for an active-low CPU strobe
// with edge detect; resets to the inactive (high) level.
`timescale 1ns/1ps
module pic_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sr;
    logic              prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr   <= '1;
            prev <= 1'b1;
        end else begin
            sr   <= {sr[STAGES-2:0], din};
            prev <= sr[STAGES-1];
        end
    end

    assign sync = sr[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/pic_cmd_regfile.sv
// pic_cmd_regfile: PIC read/write control, ICW/OCW register file and
// read-back mux. Define PIC_POLL_EN to add OCW3 poll reads and poll_ack.
`timescale 1ns/1ps
module pic_cmd_regfile
    import pic_pkg::*;
#(
    parameter int DW          = 8,
    parameter int NIRQ        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            csn,
    input  logic            rdn,
    input  logic            wrn,
    input  logic            a0,
    input  logic [DW-1:0]   d_in,
    output logic [DW-1:0]   d_out,
    output logic            d_oe,
    input  logic [NIRQ-1:0] irr,
    input  logic [NIRQ-1:0] isr,
    output logic [NIRQ-1:0] imr,
    output logic [7:0]      icw1,
    output logic [7:0]      icw2,
    output logic [7:0]      icw3,
    output logic [7:0]      icw4,
    output logic [7:0]      ocw2,
    output logic            ocw2_stb,
    output logic            smm,
    output logic            init_done
`ifdef PIC_POLL_EN
    ,
    output logic            poll_ack
`endif
);

    logic cs_s, cs_rise, cs_fall;
    logic rd_s, rd_rise, rd_fall;
    logic wr_s, wr_rise, wr_fall;

    pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(clk), .rstn(rstn), .din(csn),
        .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd (
        .clk(clk), .rstn(rstn), .din(rdn),
        .sync(rd_s), .rise(rd_rise), .fall(rd_fall)
    );
    pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr (
        .clk(clk), .rstn(rstn), .din(wrn),
        .sync(wr_s), .rise(wr_rise), .fall(wr_fall)
    );

    logic          wa0_q;
    logic [DW-1:0] wd_q;
    logic [7:0]    wb;
    logic          wr_clash;
    logic          ris;
    logic          commit;
    logic          rd_act;
    logic [DW-1:0] rdata;
    pic_state_e    state_q, state_d;
    pic_cmd_e      cmd;
    logic          sync_unused;

    assign sync_unused = ^{cs_rise, cs_fall, rd_rise, rd_fall, wr_fall, wd_q};

    assign wb        = wd_q[7:0];
    assign init_done = (state_q == READY);
    assign rd_act    = ~cs_s & ~rd_s;
    // a read overlapping the write, or chip select lost first, drops it
    assign commit    = wr_rise & ~cs_s & rd_s & ~wr_clash;

    always_comb begin
        cmd     = CMD_NONE;
        state_d = state_q;
        if (commit) begin
            cmd = cmd_decode(wa0_q, wb, state_q == READY);
        end
        case (cmd)
            CMD_ICW1: state_d = WAIT_ICW2;
            CMD_ICWN: begin
                case (state_q)
                    WAIT_ICW2: begin
                        if (!icw1[ICW1_SNGL])
                            state_d = WAIT_ICW3;
                        else if (icw1[ICW1_IC4])
                            state_d = WAIT_ICW4;
                        else
                            state_d = READY;
                    end
                    WAIT_ICW3:
                        state_d = icw1[ICW1_IC4] ? WAIT_ICW4 : READY;
                    WAIT_ICW4:
                        state_d = READY;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef PIC_POLL_EN
    logic       poll_pend;
    logic       poll_rd;
    logic [2:0] lvl;
    logic [7:0] poll_word;

    always_comb begin
        lvl = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irr[i]) lvl = 3'(i);
        end
        poll_word = {|irr, 4'b0000, lvl};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            poll_pend <= 1'b0;
            poll_rd   <= 1'b0;
            poll_ack  <= 1'b0;
        end else begin
            poll_ack <= d_oe & ~rd_act & poll_rd;
            if (d_oe & ~rd_act & poll_rd) begin
                poll_pend <= 1'b0;
                poll_rd   <= 1'b0;
            end else if (rd_act & poll_pend & ~a0) begin
                poll_rd <= 1'b1;
            end
            if ((cmd == CMD_OCW3) && wb[OCW3_P]) begin
                poll_pend <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (a0)
            rdata = DW'(imr);
        else if (ris)
            rdata = DW'(isr);
        else
            rdata = DW'(irr);
`ifdef PIC_POLL_EN
        if (poll_pend && !a0) rdata = DW'(poll_word);
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= WAIT_ICW1;
            wa0_q    <= 1'b0;
            wd_q     <= '0;
            wr_clash <= 1'b0;
            icw1     <= 8'h00;
            icw2     <= 8'h00;
            icw3     <= 8'h00;
            icw4     <= 8'h00;
            ocw2     <= 8'h00;
            ocw2_stb <= 1'b0;
            imr      <= '0;
            ris      <= 1'b0;
            smm      <= 1'b0;
            d_out    <= '0;
            d_oe     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ocw2_stb <= 1'b0;
            d_oe     <= rd_act;
            if (rd_act) d_out <= rdata;
            if (~wr_s & ~cs_s) begin
                wa0_q <= a0;
                wd_q  <= d_in;
            end
            wr_clash <= wr_rise ? 1'b0 : (wr_clash | (~wr_s & ~rd_s));
            case (cmd)
                CMD_ICW1: begin
                    icw1 <= wb;
                    icw2 <= 8'h00;
                    icw3 <= 8'h00;
                    icw4 <= 8'h00;
                    imr  <= '0;
                    ris  <= 1'b0;
                    smm  <= 1'b0;
                end
                CMD_ICWN: begin
                    case (state_q)
                        WAIT_ICW2: icw2 <= wb;
                        WAIT_ICW3: icw3 <= wb;
                        WAIT_ICW4: icw4 <= wb;
                        default: ;
                    endcase
                end
                CMD_OCW1: imr <= wd_q[NIRQ-1:0];
                CMD_OCW2: begin
                    ocw2     <= wb;
                    ocw2_stb <= 1'b1;
                end
                CMD_OCW3: begin
                    if (wb[OCW3_RR])   ris <= wb[OCW3_RIS];
                    if (wb[OCW3_ESMM]) smm <= wb[OCW3_SMM];
                end
                default: ;
            endcase
        end
    end

endmodule
